chess_clock_ctrl: RTL and testbench

- Game controller for the two-player chess clock.
- Runs per-player countdown timers and alternates turns on player button presses.
- Handles pause/resume and flag-fall detection.
- Drives the winner display segment driver: enable plus win select, where win=1 shows "A" and win=0 shows "b".
- Sits between the debounced button inputs and the time/winner display blocks.

---
 rtl/chess_clock_if.sv | 42 ++++
 rtl/chess_clock_ctrl.sv | 158 +++++++++++++++
 tb/tb_chess_clock_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/chess_clock_if.sv
// Chess clock controller bundle: debounced button levels in,
// player times, turn, run flag and winner display drive out.
interface chess_clock_if #(
  parameter int TIME_W = 10
);
  logic              btn_start;
  logic              btn_pause;
  logic              btn_a;
  logic              btn_b;
  logic [TIME_W-1:0] time_a;
  logic [TIME_W-1:0] time_b;
  logic              turn;
  logic              running;
  logic              seg_en;
  logic              seg_win;

  modport master (
    output btn_start,
    output btn_pause,
    output btn_a,
    output btn_b,
    input  time_a,
    input  time_b,
    input  turn,
    input  running,
    input  seg_en,
    input  seg_win
  );

  modport slave (
    input  btn_start,
    input  btn_pause,
    input  btn_a,
    input  btn_b,
    output time_a,
    output time_b,
    output turn,
    output running,
    output seg_en,
    output seg_win
  );
endinterface

// File: rtl/chess_clock_ctrl.sv
// Two-player chess clock game controller: turn alternation,
// pause/resume, per-player countdown and flag-fall detection.
// Ports: clk, rst (sync, active-high), bus (slave side):
//   btn_start/btn_pause/btn_a/btn_b in, time_a/time_b/turn/
//   running/seg_en/seg_win out (seg_win=1: A wins).
module chess_clock_ctrl #(
  parameter int TICK_DIV = 100_000_000,
  parameter int TIME_W   = 10,
  parameter int INIT_SEC = 300
) (
  input  logic          clk,
  input  logic          rst,
  chess_clock_if.slave  bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [TIME_W-1:0] T_INIT = TIME_W'(INIT_SEC);
  localparam logic [TIME_W-1:0] T_ONE = TIME_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN_A,
    S_RUN_B,
    S_PAUSE,
    S_OVER
  } state_t;

  // bit order: [3] start, [2] pause, [1] a, [0] b
  logic [3:0] raw;
  logic [3:0] lvl;
  logic [3:0] prev;
  logic [3:0] blk;
  logic [3:0] press;

  assign raw = {bus.btn_start, bus.btn_pause,
                bus.btn_a, bus.btn_b};

  // blk masks any button that has stayed high since reset, so
  // a level held through reset never counts as a press.
  assign press = lvl & ~prev & ~blk;

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl  <= '0;
      prev <= '0;
      blk  <= '1;
    end else begin
      lvl  <= raw;
      prev <= lvl;
      blk  <= blk & raw;
    end
  end

  state_t            state;
  logic [PW-1:0]     pre;
  logic [TIME_W-1:0] ta;
  logic [TIME_W-1:0] tb;
  logic              turn_q;
  logic              run_q;
  logic              en_q;
  logic              win_q;

  logic              in_run;
  logic              tick;
  logic [TIME_W-1:0] act_t;
  logic              expire;
  logic              own;
  logic [PW-1:0]     pre_nx;

  assign in_run = (state == S_RUN_A) || (state == S_RUN_B);
  assign tick   = in_run && (pre == PRE_MAX);
  assign act_t  = turn_q ? tb : ta;
  assign expire = tick && (act_t == T_ONE);
  assign own    = turn_q ? press[0] : press[1];
  assign pre_nx = tick ? '0 : pre + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pre    <= '0;
      ta     <= T_INIT;
      tb     <= T_INIT;
      turn_q <= 1'b0;
      run_q  <= 1'b0;
      en_q   <= 1'b0;
      win_q  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          ta     <= T_INIT;
          tb     <= T_INIT;
          turn_q <= 1'b0;
          pre    <= '0;
          if (press[3]) begin
            state <= S_RUN_A;
            run_q <= 1'b1;
          end
        end
        S_RUN_A, S_RUN_B: begin
          if (expire) begin
            // flag fall outranks pause and turn presses
            if (turn_q) tb <= '0;
            else        ta <= '0;
            state <= S_OVER;
            run_q <= 1'b0;
            en_q  <= 1'b1;
            win_q <= turn_q;
            pre   <= '0;
          end else begin
            if (tick) begin
              if (turn_q) tb <= tb - T_ONE;
              else        ta <= ta - T_ONE;
            end
            pre <= pre_nx;
            if (press[2]) begin
              state <= S_PAUSE;
              run_q <= 1'b0;
            end else if (own) begin
              state  <= turn_q ? S_RUN_A : S_RUN_B;
              turn_q <= ~turn_q;
              pre    <= '0;
            end
          end
        end
        S_PAUSE: begin
          if (press[2]) begin
            state <= turn_q ? S_RUN_B : S_RUN_A;
            run_q <= 1'b1;
          end
        end
        S_OVER: begin
          if (press[3]) begin
            state  <= S_IDLE;
            ta     <= T_INIT;
            tb     <= T_INIT;
            turn_q <= 1'b0;
            en_q   <= 1'b0;
            pre    <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          run_q <= 1'b0;
          en_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.time_a  = ta;
  assign bus.time_b  = tb;
  assign bus.turn    = turn_q;
  assign bus.running = run_q;
  assign bus.seg_en  = en_q;
  assign bus.seg_win = win_q;

endmodule

// File: tb/tb_chess_clock_ctrl.sv
// Bench for chess_clock_ctrl: directed game scenarios plus
// random button traffic against a game-rule reference model.
module tb_chess_clock_ctrl;

  localparam int TD = 4;
  localparam int TW = 10;
  localparam int IS = 3;

  localparam int M_IDLE  = 0;
  localparam int M_RA    = 1;
  localparam int M_RB    = 2;
  localparam int M_PAUSE = 3;
  localparam int M_OVER  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  chess_clock_if #(.TIME_W(TW)) bus();

  chess_clock_ctrl #(
    .TICK_DIV(TD),
    .TIME_W(TW),
    .INIT_SEC(IS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference game state
  int m_st, m_ta, m_tb, m_turn, m_pre, m_win;
  bit [3:0] s1, s2;
  int nv;

  // A press is recognised when the two most recent post-reset
  // samples of a button read 0 then 1.
  task automatic model_edge(input bit r, input bit [3:0] cur);
    bit [3:0] p;
    bit tick, own;
    int act;
    if (r) begin
      m_st = M_IDLE; m_ta = IS; m_tb = IS;
      m_turn = 0; m_pre = 0; m_win = 0;
      nv = 0; s1 = '0; s2 = '0;
      return;
    end
    p = (nv >= 2) ? (s1 & ~s2) : 4'b0;
    tick = (m_st == M_RA || m_st == M_RB) && (m_pre == TD - 1);
    case (m_st)
      M_IDLE: begin
        m_ta = IS; m_tb = IS; m_turn = 0; m_pre = 0;
        if (p[3]) m_st = M_RA;
      end
      M_RA, M_RB: begin
        act = m_turn ? m_tb : m_ta;
        own = m_turn ? p[0] : p[1];
        if (tick && act == 1) begin
          if (m_turn) m_tb = 0; else m_ta = 0;
          m_win = m_turn ? 1 : 0;
          m_st = M_OVER;
        end else begin
          if (tick) begin
            if (m_turn) m_tb--; else m_ta--;
          end
          m_pre = tick ? 0 : m_pre + 1;
          if (p[2]) m_st = M_PAUSE;
          else if (own) begin
            m_turn = 1 - m_turn;
            m_st = m_turn ? M_RB : M_RA;
            m_pre = 0;
          end
        end
      end
      M_PAUSE: begin
        if (p[2]) m_st = m_turn ? M_RB : M_RA;
      end
      default: begin
        if (p[3]) begin
          m_st = M_IDLE; m_ta = IS; m_tb = IS; m_turn = 0;
        end
      end
    endcase
    s2 = s1;
    s1 = cur;
    if (nv < 2) nv++;
  endtask

  task automatic compare_all();
    chk("time_a", bus.time_a, m_ta);
    chk("time_b", bus.time_b, m_tb);
    chk("turn", bus.turn, m_turn);
    chk("running", bus.running,
        (m_st == M_RA || m_st == M_RB) ? 1 : 0);
    chk("seg_en", bus.seg_en, (m_st == M_OVER) ? 1 : 0);
    if (m_st == M_OVER) chk("seg_win", bus.seg_win, m_win);
  endtask

  task automatic step(input bit r, input bit [3:0] b);
    @(negedge clk);
    rst = r;
    bus.btn_start = b[3];
    bus.btn_pause = b[2];
    bus.btn_a     = b[1];
    bus.btn_b     = b[0];
    @(posedge clk);
    #1;
    model_edge(r, b);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'b0000);
  endtask

  task automatic do_reset();
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
  endtask

  initial begin
    bit [3:0] lv;
    bit r;
    bus.btn_start = 1'b0;
    bus.btn_pause = 1'b0;
    bus.btn_a = 1'b0;
    bus.btn_b = 1'b0;

    // reset state
    do_reset();
    chk("rst_time_a", bus.time_a, IS);
    chk("rst_time_b", bus.time_b, IS);
    chk("rst_turn", bus.turn, 0);
    chk("rst_running", bus.running, 0);
    chk("rst_seg_en", bus.seg_en, 0);
    idle(2);

    // start, first tick, turn change, first B tick
    step(1'b0, 4'b1000);
    step(1'b0, 4'b0000);
    chk("start_running", bus.running, 1);
    idle(3);
    chk("pre_tick_a", bus.time_a, 3);
    idle(1);
    chk("tick_a", bus.time_a, 2);
    chk("tick_b_hold", bus.time_b, 3);
    step(1'b0, 4'b0010);
    step(1'b0, 4'b0000);
    chk("swap_turn", bus.turn, 1);
    idle(3);
    chk("pre_tick_b", bus.time_b, 3);
    idle(1);
    chk("tick_b", bus.time_b, 2);

    // A runs out of time
    do_reset();
    idle(2);
    step(1'b0, 4'b1000);
    step(1'b0, 4'b0000);
    idle(12);
    chk("exp_time_a", bus.time_a, 0);
    chk("exp_seg_en", bus.seg_en, 1);
    chk("exp_seg_win", bus.seg_win, 0);
    chk("exp_running", bus.running, 0);
    step(1'b0, 4'b0011);
    step(1'b0, 4'b0000);
    idle(2);
    chk("over_frozen_a", bus.time_a, 0);
    chk("over_frozen_b", bus.time_b, IS);
    chk("over_turn", bus.turn, 0);

    // pause with prescaler held at 2, resume
    do_reset();
    idle(2);
    step(1'b0, 4'b1000);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0000);
    chk("pause_running", bus.running, 0);
    idle(20);
    chk("pause_hold_a", bus.time_a, IS);
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0000);
    chk("resume_running", bus.running, 1);
    idle(1);
    chk("resume_a_1", bus.time_a, 3);
    idle(1);
    chk("resume_a_2", bus.time_a, 2);

    // B's turn press coincides with B's expiry tick
    do_reset();
    idle(2);
    step(1'b0, 4'b1000);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0010);
    step(1'b0, 4'b0000);
    idle(10);
    chk("b_last_sec", bus.time_b, 1);
    step(1'b0, 4'b0001);
    step(1'b0, 4'b0000);
    chk("bexp_seg_en", bus.seg_en, 1);
    chk("bexp_seg_win", bus.seg_win, 1);
    chk("bexp_time_b", bus.time_b, 0);
    chk("bexp_turn", bus.turn, 1);

    // held btn_b gives a single turn change; then reset in RUN_B
    do_reset();
    idle(2);
    step(1'b0, 4'b1000);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0010);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0001);
    step(1'b0, 4'b0001);
    step(1'b0, 4'b0001);
    step(1'b0, 4'b0000);
    idle(2);
    chk("held_b_turn", bus.turn, 0);
    step(1'b0, 4'b0010);
    step(1'b0, 4'b0000);
    chk("back_to_b", bus.turn, 1);
    step(1'b1, 4'b0001);
    chk("midrst_turn", bus.turn, 0);
    chk("midrst_time_a", bus.time_a, IS);
    chk("midrst_running", bus.running, 0);
    step(1'b0, 4'b0001);
    step(1'b0, 4'b0001);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b1000);
    step(1'b0, 4'b0000);
    chk("restart_turn", bus.turn, 0);
    chk("restart_running", bus.running, 1);

    // random button traffic, occasional reset
    lv = '0;
    for (int i = 0; i < 5000; i++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 5) == 0) lv[k] = ~lv[k];
      r = ($urandom_range(0, 499) == 0);
      step(r, lv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
